// File: rtl/regfile_write_arbiter_pkg.sv
//------------------------------------------------------------------------------
// regarb_pkg : shared constants for the register-file write arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regarb_pkg;

  localparam int NUM_REQ_DEF = 3;
  localparam int ADDR_W_DEF  = 3;
  localparam int DATA_W_DEF  = 32;
  localparam int CNT_W_DEF   = 16;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_DBG  = 2;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
//------------------------------------------------------------------------------
// regfile_write_arbiter_if : requester handshake and register-file write port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface regfile_write_arbiter_if
  import regarb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      reg_write;
  logic [ADDR_W-1:0]         write_reg;
  logic [DATA_W-1:0]         write_data;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, reg_write, write_reg, write_data
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, reg_write, write_reg, write_data
  );

endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick starting at rr_ptr
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import regarb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = ptr_w(NUM_REQ_DEF)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  input  logic               hold,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner
);

  int   idx;
  logic found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PTR_W'(idx);
      end
    end
    if (hold) grant = '0;
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
//------------------------------------------------------------------------------
// regfile_write_arbiter : round-robin sharing of the register-file write port
// Optional: REGARB_R0_PROTECT_EN makes r0 read-only. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_write_arbiter_if.slave bus,
  input  logic                 hold,
  output logic [NUM_REQ-1:0]   last_grant,
  output logic [CNT_W-1:0]     wr_count,
  output logic                 r0_drop
);

  localparam int PTR_W = ptr_w(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   winner;
  logic               transfer;
  logic               drop;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic               reg_write_q;
  logic [ADDR_W-1:0]  write_reg_q;
  logic [DATA_W-1:0]  write_data_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .hold      (hold),
    .grant     (grant),
    .winner    (winner)
  );

  assign bus.req_ready = grant;
  assign transfer      = |grant;
  assign win_addr      = addr_arr[winner];
  assign win_data      = data_arr[winner];

`ifdef REGARB_R0_PROTECT_EN
  assign drop = transfer && (win_addr == '0);
`else
  assign drop = 1'b0;
`endif

  // Pointer and last_grant follow every grant, even one whose write is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      last_grant   <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      wr_count     <= '0;
    end else begin
      reg_write_q <= transfer && !drop;
      if (transfer) begin
        last_grant <= grant;
        rr_ptr     <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
      if (transfer && !drop) begin
        write_reg_q  <= win_addr;
        write_data_q <= win_data;
        wr_count     <= wr_count + 1'b1;
      end
    end
  end

`ifdef REGARB_R0_PROTECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r0_drop <= 1'b0;
    else        r0_drop <= drop;
  end
`else
  assign r0_drop = 1'b0;
`endif

  assign bus.reg_write  = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 8×32 register file among several writeback sources (ALU, load unit, debug/config loader). Selection is round-robin with a valid/ready handshake per requester. The winning request is registered and presented to the register file's `reg_write`/`write_reg`/`write_data` inputs one cycle later. The block sits between the writeback sources and the register block.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters; index 0 is ALU, 1 is load, 2 is debug.
- `ADDR_W`, 3: register index width.
- `DATA_W`, 32: register data width.
- `CNT_W`, 16: width of the issued-write counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in NUM_REQ: per-requester write request.
- `req_addr` in NUM_REQ*ADDR_W: packed target indices; requester i occupies `[i*ADDR_W +: ADDR_W]`.
- `req_data` in NUM_REQ*DATA_W: packed write data, same packing.
- `req_ready` out NUM_REQ: one-hot grant, combinational.
- `hold` in 1: when 1, no new grant is issued (used for register-file dump/snapshot).
- `reg_write` out 1: write enable to the register file.
- `write_reg` out ADDR_W: write index to the register file.
- `write_data` out DATA_W: write data to the register file.
- `last_grant` out NUM_REQ: one-hot index of the most recent accepted requester.
- `wr_count` out CNT_W: number of writes issued since reset.
- `r0_drop` out 1: one-cycle pulse when a write to r0 is discarded (see Configuration).

## Operation
- Round-robin pointer `rr_ptr` holds values 0..NUM_REQ-1.
- Grant rule:
  - The winner is the first i with `req_valid[i]`=1, searching i = rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - `req_ready` is one-hot on the winner.
  - `req_ready` is all zero if `hold`=1 or no requester is valid.
- `req_ready` may depend on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- A transfer occurs on a clock edge when `req_valid[i]` & `req_ready[i]`. On a transfer:
  - `write_reg` ← addr, `write_data` ← data, `reg_write` ← 1.
  - `last_grant` ← one-hot(i).
  - `rr_ptr` ← (i+1) mod NUM_REQ.
  - `wr_count` ← `wr_count`+1, wrapping modulo 2^CNT_W.
- No transfer: `reg_write` ← 0. `write_reg`, `write_data`, `last_grant` and `rr_ptr` hold their values.
- A requester keeps `req_valid`, addr and data stable until it receives `req_ready`. A valid request that has not been granted may not be withdrawn.
- Asserting `hold` does not cancel a write already registered; that write completes on the next cycle.

## Timing
- Reset values:
  - `reg_write`=0, `write_reg`=0, `write_data`=0.
  - `last_grant`=0, `wr_count`=0, `r0_drop`=0, `rr_ptr`=0.
- Asserting `rst_n` low mid-operation clears a pending registered write immediately; that write is lost.
- Latency: a request accepted at edge N produces `reg_write`=1 in cycle N..N+1, and the register file commits the write at edge N+1.
- Throughput: one write per cycle. With all requesters continuously valid, grants rotate 0,1,2,0,…
- Starvation bound: a valid requester is granted within NUM_REQ cycles of `hold` deasserting.
- Single valid requester: granted every cycle, and the pointer still advances past it.
- `hold` is sampled combinationally. Raising it in a cycle suppresses that cycle's grant.

## Configuration
- Macro `REGARB_R0_PROTECT_EN`.
- When defined, r0 is read-only:
  - A request to addr 0 is still granted; `rr_ptr` and `last_grant` update normally.
  - `reg_write` stays 0 and `wr_count` does not increment.
  - `write_reg`/`write_data` hold their values.
  - `r0_drop` pulses 1 for one cycle.
- When not defined: addr 0 is written like any other register and `r0_drop` is tied to 0.

## Structure
- Package `regarb_pkg`:
  - Default constants for `NUM_REQ`, `ADDR_W`, `DATA_W`, `CNT_W`.
  - Requester index constants `REQ_ALU`=0, `REQ_LOAD`=1, `REQ_DBG`=2.
- Sub-module `rr_arbiter`:
  - Inputs: `req_valid`, `rr_ptr`, `hold`.
  - Outputs: one-hot grant and winner index.
  - Purely combinational.
- The top level holds the pointer, output register and counter.

## Test plan
- Reset: hold `rst_n`=0 with all requesters valid → `reg_write`=0, `req_ready`=000 is not required during reset, and all outputs read 0 after release until the first edge.
- Single request: requester 1 valid, addr 5, data 0xDEADBEEF → `req_ready`=010. One cycle later `reg_write`=1, `write_reg`=5, `write_data`=0xDEADBEEF, `last_grant`=010, `wr_count`=1.
- Contention: all three valid for 6 cycles → grant order 0,1,2,0,1,2 and `wr_count`=6.
- Hold: all valid, `hold`=1 for 3 cycles → `req_ready`=000 and `reg_write`=0 from the second cycle. Release → the grant resumes at the saved `rr_ptr`.
- R0 protect (macro defined): requester 2 writes addr 0 → `r0_drop` pulses, `reg_write`=0, `wr_count` unchanged. Without the macro → `reg_write`=1 and `write_reg`=0.
- Reset mid-write: accept a request, pull `rst_n` low before the next edge → `reg_write` drops to 0 immediately and `wr_count`=0.
